// File: rtl/ysyx_23060236_div_iter.sv
// Iterative radix-2 restoring divider for RV32M div/divu/rem/remu; 33-cycle latency, div_ready only in IDLE.
// Defining YSYX_23060236_DIV_FAST_EN finishes divide-by-zero, signed overflow and |div1|<|div2| in one cycle.
module ysyx_23060236_div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        div_sign,
  input  logic [31:0] div1,
  input  logic [31:0] div2,
  output logic [31:0] res,
  output logic [31:0] rem,
  output logic        div_outvalid
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] res_q, res_d;
  logic [31:0] rem_q, rem_d;

  logic        accept;
  logic [31:0] abs1, abs2;
  logic [32:0] partial;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] step;

  assign accept = div_valid & (state_q == IDLE);
  assign abs1   = (div_sign & div1[31]) ? (~div1 + 32'd1) : div1;
  assign abs2   = (div_sign & div2[31]) ? (~div2 + 32'd1) : div2;

  // partial is the shifted upper half; its MSB is the bit shifted out of the remainder
  assign partial = work_q[63:31];
  assign ge      = partial >= {1'b0, dvsr_q};
  assign diff    = partial[31:0] - dvsr_q;
  assign step    = ge ? {diff, work_q[30:0], 1'b1}
                      : {partial[31:0], work_q[30:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          negq_d  = div_sign & (div1[31] ^ div2[31]) & (div2 != 32'd0);
          negr_d  = div_sign & div1[31];
          work_d  = {32'd0, abs1};
          dvsr_d  = abs2;
          cnt_d   = 5'd31;
          state_d = CALC;
`ifdef YSYX_23060236_DIV_FAST_EN
          if (div2 == 32'd0) begin
            res_d   = 32'hFFFF_FFFF;
            rem_d   = div1;
            state_d = DONE;
          end else if (div_sign && div1 == 32'h8000_0000 && div2 == 32'hFFFF_FFFF) begin
            res_d   = 32'h8000_0000;
            rem_d   = 32'd0;
            state_d = DONE;
          end else if (abs1 < abs2) begin
            res_d   = 32'd0;
            rem_d   = div1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        work_d = step;
        cnt_d  = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          res_d   = negq_q ? (~step[31:0] + 32'd1) : step[31:0];
          rem_d   = negr_q ? (~step[63:32] + 32'd1) : step[63:32];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      work_q  <= 64'd0;
      dvsr_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
    end
  end

  assign div_ready    = (state_q == IDLE);
  assign div_outvalid = (state_q == DONE);
  assign res          = res_q;
  assign rem          = rem_q;

endmodule

// File: tb/tb_ysyx_23060236_div_iter.sv
// Bench for ysyx_23060236_div_iter: directed test-plan vectors, handshake timing, resets and random operands.
module tb_ysyx_23060236_div_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        div_valid;
  logic        div_ready;
  logic        div_sign;
  logic [31:0] div1;
  logic [31:0] div2;
  logic [31:0] res;
  logic [31:0] rem;
  logic        div_outvalid;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  bit prev_ov = 1'b0;

`ifdef YSYX_23060236_DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  ysyx_23060236_div_iter dut (
    .clock(clock), .reset(reset), .div_valid(div_valid), .div_ready(div_ready),
    .div_sign(div_sign), .div1(div1), .div2(div2), .res(res), .rem(rem),
    .div_outvalid(div_outvalid)
  );

  always #5 clock = ~clock;

  // Scoreboard: every completion pops the oldest expected {res, rem}
  always @(negedge clock) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (div_outvalid) begin
        checks++;
        if (prev_ov) begin
          errors++;
          $display("FAIL outvalid_double: div_outvalid high two cycles in a row, required single pulse");
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_outvalid: res=%h rem=%h with no request pending", res, rem);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          if ({res, rem} !== e)
            begin
              errors++;
              $display("FAIL result: res=%h rem=%h, required res=%h rem=%h", res, rem, e[63:32], e[31:0]);
            end
        end
      end
      prev_ov = div_outvalid;
    end
  end

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv, q, r;
    sa = a;
    sbv = b;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    q = sa / sbv;
    r = sa % sbv;
    return {q, r};
  endfunction

  function automatic int lat_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb;
    bit quick;
    aa = (s && a[31]) ? -a : a;
    bb = (s && b[31]) ? -b : b;
    quick = (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (aa < bb);
    return (FAST && quick) ? 1 : 33;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!div_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!div_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: div_ready=%b, required 1 within 100 cycles", div_ready);
    end
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] em, input string name);
    int lat, exp_lat;
    exp_lat = lat_model(s, a, b);
    @(negedge clock);
    wait_idle();
    div_valid = 1'b1;
    div_sign  = s;
    div1      = a;
    div2      = b;
    @(posedge clock);
    sb.push_back({er, em});
    #1;
    div_valid = 1'b0;
    div1      = $urandom;
    div2      = $urandom;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (div_outvalid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency_%s: outvalid in cycle %0d, required cycle %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    div_valid = 1'b0;
    div_sign = 1'b0;
    div1 = 32'd0;
    div2 = 32'd0;
    repeat (2) @(negedge clock);
    checks++;
    if ({div_ready, div_outvalid, res, rem} !== {1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_state: ready=%b outvalid=%b res=%h rem=%h, required 1 0 0 0",
               div_ready, div_outvalid, res, rem);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u100_7");
    repeat (3) @(negedge clock);
    checks++;
    if (res !== 32'd14 || rem !== 32'd2) begin
      errors++;
      $display("FAIL hold_result: res=%h rem=%h, required 0000000e 00000002", res, rem);
    end
  endtask

  task automatic test_signed();
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "sm100_7");
    do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, "s100_m7");
  endtask

  task automatic test_div_zero();
    do_op(1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, "sdivzero");
    do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "udivzero");
  endtask

  task automatic test_overflow();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "sovf");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "uovf");
  endtask

  task automatic test_back_to_back();
    int accepts;
    accepts = 0;
    @(negedge clock);
    wait_idle();
    sb.push_back({32'd333, 32'd1});
    sb.push_back({32'd15, 32'd2});
    div_valid = 1'b1;
    div_sign  = 1'b0;
    div1      = 32'd1000;
    div2      = 32'd3;
    for (int c = 0; c <= 34; c++) begin
      checks++;
      if (div_ready !== ((c == 0) || (c == 34))) begin
        errors++;
        $display("FAIL ready_cycle%0d: div_ready=%b, required %b", c, div_ready, (c == 0) || (c == 34));
      end
      checks++;
      if (div_outvalid !== (c == 33)) begin
        errors++;
        $display("FAIL outvalid_cycle%0d: div_outvalid=%b, required %b", c, div_outvalid, c == 33);
      end
      if (c <= 33 && div_valid && div_ready) accepts++;
      if (c >= 1 && c <= 33) begin
        div1     = $urandom;
        div2     = $urandom;
        div_sign = $urandom_range(0, 1);
      end else if (c == 34) begin
        div_sign = 1'b0;
        div1     = 32'd77;
        div2     = 32'd5;
      end
      @(negedge clock);
    end
    div_valid = 1'b0;
    checks++;
    if (accepts !== 1) begin
      errors++;
      $display("FAIL accept_count: %0d accepts in cycles 0-33, required 1", accepts);
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL second_request: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic quiet_check(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (div_outvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL %s_no_outvalid: %0d pulses, required 0", name, seen);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clock);
    wait_idle();
    div_valid = 1'b1;
    div_sign  = 1'b0;
    div1      = 32'hFFFF_FFF0;
    div2      = 32'd3;
    @(posedge clock);
    #1;
    div_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({div_ready, div_outvalid, res, rem} !== {1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL abort_state: ready=%b outvalid=%b res=%h rem=%h, required 1 0 0 0",
               div_ready, div_outvalid, res, rem);
    end
    quiet_check("abort");
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "after_abort");
  endtask

  task automatic test_reset_with_valid();
    @(negedge clock);
    wait_idle();
    reset     = 1'b1;
    div_valid = 1'b1;
    div_sign  = 1'b0;
    div1      = 32'd50;
    div2      = 32'd7;
    @(negedge clock);
    reset     = 1'b0;
    div_valid = 1'b0;
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_drop_ready: div_ready=%b, required 1", div_ready);
    end
    quiet_check("reset_drop");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      e = model(s, a, b);
      do_op(s, a, b, e[63:32], e[31:0], $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_with_valid();
    test_random();
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
